// File: rtl/load_store_unit_pkg.sv
// Shared RV32I load/store definitions: width codes, LSU state encoding,
// and the legality/alignment checks used by the fault logic.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic f3_load_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Stores have no unsigned variants.
  function automatic logic f3_store_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return (((f3 == F3_H) || (f3 == F3_HU)) && off[0]) ||
           ((f3 == F3_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store-side byte enables and replicated write data,
// load-side lane select with sign/zero extension. Purely combinational.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_offset,
  input  logic [31:0] store_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] rdata,
  output logic [31:0] ldata
);

  logic [7:0]  byte_l;
  logic [15:0] half_l;

  // Store side: width comes from funct3[1:0]; only legal codes ever get registered.
  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    case (st_funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << st_offset;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        be    = st_offset[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = store_data;
      end
    endcase
  end

  // Load side: pick the addressed lane, then extend according to funct3.
  always_comb begin
    case (ld_offset)
      2'd0:    byte_l = rdata[7:0];
      2'd1:    byte_l = rdata[15:8];
      2'd2:    byte_l = rdata[23:16];
      default: byte_l = rdata[31:24];
    endcase
    half_l = ld_offset[1] ? rdata[31:16] : rdata[15:0];
    case (ld_funct3)
      F3_B:    ldata = {{24{byte_l[7]}}, byte_l};
      F3_H:    ldata = {{16{half_l[15]}}, half_l};
      F3_BU:   ldata = {24'd0, byte_l};
      F3_HU:   ldata = {16'd0, half_l};
      default: ldata = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: accepts a load/store from EX, runs one
// request/ready transaction on the data port, stalls upstream meanwhile,
// and returns the extended load result as a one-cycle pulse.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        fault,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata
);

  lsu_state_e  state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] ldata_q, ldata_d;

  logic        accept;
  logic        illegal;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_ext;

  lsu_align u_align (
    .st_funct3  (funct3),
    .st_offset  (addr[1:0]),
    .store_data (store_data),
    .be         (st_be),
    .wdata      (st_wdata),
    .ld_funct3  (f3_q),
    .ld_offset  (off_q),
    .rdata      (dmem_rdata),
    .ldata      (ld_ext)
  );

  // Fault detection and accept qualification; a faulting op never reaches the bus.
  always_comb begin
    illegal = (mem_read & mem_write) ||
              (mem_read  & !f3_load_legal(funct3)) ||
              (mem_write & !f3_store_legal(funct3)) ||
              f3_misaligned(funct3, addr[1:0]);
    fault   = ex_valid & (mem_read | mem_write) & illegal;
    accept  = ((state_q == ST_IDLE) || (state_q == ST_DONE)) &
              ex_valid & (mem_read ^ mem_write) & !fault;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: DONE is a single cycle that can chain straight into a new request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_REQ;
      ST_REQ:  if (dmem_ready) state_d = ST_DONE;
      ST_DONE: state_d = accept ? ST_REQ : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    dmem_req   = (state_q == ST_REQ);
    dmem_we    = dmem_req & we_q;
    stall      = dmem_req | accept;
    load_valid = (state_q == ST_DONE) & !we_q;
  end

  // Transaction registers: captured on accept, held through REQ; load result captured on handshake.
  always_comb begin
    off_d   = off_q;
    f3_d    = f3_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    ldata_d = ldata_q;
    if (accept) begin
      off_d   = addr[1:0];
      f3_d    = funct3;
      we_d    = mem_write;
      be_d    = st_be;
      wdata_d = st_wdata;
      addr_d  = {addr[31:2], 2'b00};
    end
    if ((state_q == ST_REQ) && dmem_ready && !we_q) ldata_d = ld_ext;
  end

  // Datapath flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q   <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      ldata_q <= '0;
    end else begin
      off_q   <= off_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      ldata_q <= ldata_d;
    end
  end

  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign load_data  = ldata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected bus
// requests and load results; a negedge monitor pops and compares them.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk, rst;
  logic        ex_valid, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        stall, load_valid, fault;
  logic [31:0] load_data;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } req_t;

  req_t        req_q[$];
  logic [31:0] ld_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  load_store_unit dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .addr(addr), .store_data(store_data),
    .stall(stall), .load_data(load_data), .load_valid(load_valid), .fault(fault),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every bus handshake and every load_valid pulse must match the next expectation.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (dmem_req && dmem_ready) begin
        if (req_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_req: got addr %h, expected no request", dmem_addr);
        end else begin
          req_t e;
          e = req_q.pop_front();
          chk("req_addr", dmem_addr, e.addr);
          chk("req_be", {28'd0, dmem_be}, {28'd0, e.be});
          chk("req_we", {31'd0, dmem_we}, {31'd0, e.we});
          if (e.we) chk("req_wdata", dmem_wdata, e.wdata);
        end
      end
      if (load_valid) begin
        if (ld_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_load_valid: got data %h, expected no pulse", load_data);
        end else begin
          chk("load_data", load_data, ld_q.pop_front());
        end
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd);
    ex_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
  endtask

  task automatic idle_in();
    ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
    addr = 32'd0; store_data = 32'd0;
  endtask

  task automatic push_req(input logic [31:0] a, input logic [3:0] b, input logic w,
                          input logic [31:0] d);
    req_t r;
    r.addr = a; r.be = b; r.we = w; r.wdata = d;
    req_q.push_back(r);
  endtask

  // Single op with ready tied high: accept, request, done.
  task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdata,
                       input logic [31:0] e_addr, input logic [3:0] e_be,
                       input logic [31:0] e_wdata, input logic [31:0] e_ld);
    push_req(e_addr, e_be, wr, e_wdata);
    if (rd) ld_q.push_back(e_ld);
    dmem_ready = 1'b1; dmem_rdata = rdata;
    drive(rd, wr, f3, a, sd);
    samp(); chk("op_stall_c0", {31'd0, stall}, 32'd1); chk("op_fault_c0", {31'd0, fault}, 32'd0);
    next_cyc(); idle_in();
    samp(); chk("op_req_c1", {31'd0, dmem_req}, 32'd1);
    next_cyc();
    samp(); chk("op_lv_c2", {31'd0, load_valid}, {31'd0, rd});
    next_cyc();
  endtask

  task automatic fault_op(input string nm, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] a);
    drive(rd, wr, f3, a, 32'h1234_5678);
    samp();
    chk({nm, "_fault"}, {31'd0, fault}, 32'd1);
    chk({nm, "_stall"}, {31'd0, stall}, 32'd0);
    next_cyc(); idle_in();
    samp(); chk({nm, "_noreq"}, {31'd0, dmem_req}, 32'd0);
    next_cyc();
  endtask

  initial begin
    rst = 1'b1; dmem_ready = 1'b1; dmem_rdata = 32'd0;
    idle_in();
    samp();
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_we", {31'd0, dmem_we}, 32'd0);
    chk("rst_be", {28'd0, dmem_be}, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_ldata", load_data, 32'd0);
    chk("rst_lv", {31'd0, load_valid}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    next_cyc(); rst = 1'b0;
    next_cyc();

    // LW 0x100, ready high: exact cycle-by-cycle latency
    push_req(32'h100, 4'b1111, 1'b0, 32'd0);
    ld_q.push_back(32'hDEAD_BEEF);
    dmem_rdata = 32'hDEAD_BEEF;
    drive(1'b1, 1'b0, F3_W, 32'h100, 32'd0);
    samp(); chk("lw_stall_c0", {31'd0, stall}, 32'd1);
    next_cyc(); idle_in();
    samp();
    chk("lw_req_c1", {31'd0, dmem_req}, 32'd1);
    chk("lw_stall_c1", {31'd0, stall}, 32'd1);
    chk("lw_addr_c1", dmem_addr, 32'h100);
    chk("lw_be_c1", {28'd0, dmem_be}, 32'hF);
    chk("lw_lv_c1", {31'd0, load_valid}, 32'd0);
    next_cyc();
    samp();
    chk("lw_lv_c2", {31'd0, load_valid}, 32'd1);
    chk("lw_stall_c2", {31'd0, stall}, 32'd0);
    chk("lw_req_c2", {31'd0, dmem_req}, 32'd0);
    next_cyc();
    samp(); chk("lw_lv_c3", {31'd0, load_valid}, 32'd0);
    next_cyc();

    // LB / LBU lane 3 of 0x80FF1234
    do_op(1'b1, 1'b0, F3_B,  32'h203, 32'd0, 32'h80FF_1234, 32'h200, 4'b1000, 32'd0, 32'hFFFF_FF80);
    do_op(1'b1, 1'b0, F3_BU, 32'h203, 32'd0, 32'h80FF_1234, 32'h200, 4'b1000, 32'd0, 32'h0000_0080);
    // SW and LH lower half, sign bit clear
    do_op(1'b0, 1'b1, F3_W,  32'h504, 32'hCAFE_F00D, 32'd0, 32'h504, 4'b1111, 32'hCAFE_F00D, 32'd0);
    do_op(1'b1, 1'b0, F3_H,  32'h500, 32'd0, 32'h8000_7FFE, 32'h500, 4'b0011, 32'd0, 32'h0000_7FFE);

    // SH 0x402 with three wait cycles: request held stable
    push_req(32'h400, 4'b1100, 1'b1, 32'hABCD_ABCD);
    dmem_ready = 1'b0;
    drive(1'b0, 1'b1, F3_H, 32'h402, 32'h0000_ABCD);
    samp(); chk("sh_stall_c0", {31'd0, stall}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      next_cyc(); idle_in();
      if (k == 4) dmem_ready = 1'b1;
      samp();
      chk("sh_req_held", {31'd0, dmem_req}, 32'd1);
      chk("sh_we_held", {31'd0, dmem_we}, 32'd1);
      chk("sh_addr_held", dmem_addr, 32'h400);
      chk("sh_be_held", {28'd0, dmem_be}, 32'hC);
      chk("sh_wdata_held", dmem_wdata, 32'hABCD_ABCD);
      chk("sh_stall_held", {31'd0, stall}, 32'd1);
      chk("sh_no_lv", {31'd0, load_valid}, 32'd0);
    end
    next_cyc();
    samp();
    chk("sh_done_req", {31'd0, dmem_req}, 32'd0);
    chk("sh_done_lv", {31'd0, load_valid}, 32'd0);
    chk("sh_done_stall", {31'd0, stall}, 32'd0);
    next_cyc();

    // Faulting accesses
    fault_op("lw_mis",   1'b1, 1'b0, F3_W,   32'h101);
    fault_op("lw_mis2",  1'b1, 1'b0, F3_W,   32'h102);
    fault_op("ld_f3_011",1'b1, 1'b0, 3'b011, 32'h100);
    fault_op("lh_mis",   1'b1, 1'b0, F3_H,   32'h203);
    fault_op("st_bu",    1'b0, 1'b1, F3_BU,  32'h100);
    fault_op("rd_and_wr",1'b1, 1'b1, F3_W,   32'h100);

    // Back-to-back SB then LHU
    push_req(32'h010, 4'b0010, 1'b1, 32'h5A5A_5A5A);
    dmem_ready = 1'b1;
    drive(1'b0, 1'b1, F3_B, 32'h011, 32'h1234_565A);
    samp(); chk("b2b_stall_c0", {31'd0, stall}, 32'd1);
    next_cyc(); idle_in();
    samp(); chk("b2b_req1_c1", {31'd0, dmem_req}, 32'd1);
    next_cyc();
    push_req(32'h004, 4'b1100, 1'b0, 32'd0);
    ld_q.push_back(32'h0000_BEEF);
    dmem_rdata = 32'hBEEF_1234;
    drive(1'b1, 1'b0, F3_HU, 32'h006, 32'd0);
    samp();
    chk("b2b_done_req", {31'd0, dmem_req}, 32'd0);
    chk("b2b_done_stall", {31'd0, stall}, 32'd1);
    chk("b2b_done_lv", {31'd0, load_valid}, 32'd0);
    next_cyc(); idle_in();
    samp();
    chk("b2b_req2_c3", {31'd0, dmem_req}, 32'd1);
    chk("b2b_addr2_c3", dmem_addr, 32'h004);
    next_cyc();
    samp(); chk("b2b_lv_c4", {31'd0, load_valid}, 32'd1);
    next_cyc();

    // Reset pulsed mid-request with ready low
    dmem_ready = 1'b0;
    drive(1'b1, 1'b0, F3_W, 32'h300, 32'd0);
    samp(); chk("rq_stall_c0", {31'd0, stall}, 32'd1);
    next_cyc(); idle_in();
    samp(); chk("rq_req_c1", {31'd0, dmem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rq_async_req", {31'd0, dmem_req}, 32'd0);
    chk("rq_async_stall", {31'd0, stall}, 32'd0);
    chk("rq_async_lv", {31'd0, load_valid}, 32'd0);
    next_cyc(); rst = 1'b0; dmem_ready = 1'b1;
    samp();
    chk("rq_post_req", {31'd0, dmem_req}, 32'd0);
    chk("rq_post_lv", {31'd0, load_valid}, 32'd0);
    next_cyc();
    do_op(1'b1, 1'b0, F3_H, 32'h302, 32'd0, 32'h8765_4321, 32'h300, 4'b1100, 32'd0, 32'hFFFF_8765);

    repeat (2) next_cyc();
    chk("req_q_drained", req_q.size(), 32'd0);
    chk("ld_q_drained", ld_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage directly downstream of the ALU. It takes the ALU result as the effective address for RV32I loads and stores and runs a request/ready transaction on the data-memory port. It generates byte enables and lane-replicated write data, and returns sign- or zero-extended load data. While a transaction is outstanding it stalls the pipeline, and it flags misaligned or illegal accesses without touching memory.

## Interface
Parameters:
- none (data and address are fixed at 32 bits, RV32I)

Ports:
- clk  in  1  — single clock; all state on rising edge
- rst  in  1  — reset, asynchronous, active-high
- ex_valid  in  1  — EX stage presents an instruction this cycle
- mem_read  in  1  — instruction is a load
- mem_write  in  1  — instruction is a store
- funct3  in  3  — width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  — effective address (ALU result)
- store_data  in  32  — rs2 value
- stall  out  1  — hold upstream pipeline registers
- load_data  out  32  — extended load result, valid with load_valid
- load_valid  out  1  — one-cycle pulse: load_data is valid
- fault  out  1  — misaligned or illegal access; combinational, no bus activity
- dmem_req  out  1  — memory request, registered
- dmem_we  out  1  — write strobe, qualified by dmem_req
- dmem_addr  out  32  — word address, {addr[31:2],2'b00}
- dmem_be  out  4  — byte enables
- dmem_wdata  out  32  — lane-replicated store data
- dmem_ready  in  1  — memory accepts/completes the request this cycle
- dmem_rdata  in  32  — read word, valid when dmem_req & dmem_ready & !dmem_we

## Operation
- States: IDLE, REQ, DONE. Reset → IDLE.
- Accept condition in IDLE or DONE: ex_valid & (mem_read ^ mem_write) & !fault.
  - Accept → REQ. Register addr[1:0], funct3, we, be, wdata.
- fault = ex_valid & (mem_read | mem_write) & any of:
  - mem_read & mem_write;
  - funct3 not in the legal set (for stores, only 000/001/010 are legal);
  - H/HU with addr[0]=1;
  - W with addr[1:0]≠0.
  - A faulting op is not accepted, and the state does not change.
- REQ: dmem_req=1. dmem_addr, dmem_we, dmem_be and dmem_wdata are held stable until dmem_ready=1.
  - On handshake → DONE, and dmem_rdata is captured for loads.
- DONE: lasts one cycle. load_valid=1 for loads (0 for stores). Then → IDLE, or → REQ if a new op is accepted in that cycle.
- Byte enables:
  - B: 4'b0001<<addr[1:0], wdata={4{store_data[7:0]}}.
  - H: addr[1] ? 1100 : 0011, wdata={2{store_data[15:0]}}.
  - W: 1111, wdata=store_data.
- Load extract: select the lane by the registered offset. B/H sign-extend from bit 7/15; BU/HU zero-extend.
- Inputs are ignored in REQ; upstream is held by stall.

## Timing
- stall = (state==REQ) | accept. stall is combinational and low in DONE and IDLE otherwise.
- Latency with dmem_ready tied high:
  - accept at cycle 0;
  - dmem_req and handshake at cycle 1;
  - load_valid at cycle 2.
  - stall is high in cycles 0–1.
- Each extra wait cycle of dmem_ready adds one cycle to stall and delays load_valid by one cycle.
- Back-to-back ops: a new op is accepted in a DONE cycle. Its dmem_req rises the cycle after DONE.
- Reset values: state=IDLE, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, load_data=0, load_valid=0.
  - stall and fault are combinational and read 0 under idle inputs.
- rst asserted mid-REQ: dmem_req drops asynchronously and the transaction is abandoned. No load_valid is produced.
- dmem_ready while dmem_req=0: ignored.

## Structure
- funct3 width codes, state encoding and the legal-funct3 checks belong in the shared rv32i-defines include.
- One combinational sub-module, lsu_align, provides:
  - store side: be and wdata from (funct3, offset, store_data);
  - load side: extended result from (funct3, offset, rdata).
- The top level holds the FSM and the registers.

## Test plan
- LW addr=0x100, dmem_ready high, rdata=0xDEADBEEF:
  - dmem_addr=0x100 and be=1111 at cycle 1;
  - load_valid and load_data=0xDEADBEEF at cycle 2;
  - stall high in cycles 0–1.
- LB addr=0x203, rdata=0x80FF1234 → load_data=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH addr=0x402, store_data=0x0000ABCD, ready delayed 3 cycles:
  - dmem_addr=0x400, be=1100, wdata=0xABCDABCD, we=1, all held for 4 cycles;
  - no load_valid.
- LW addr=0x101 → fault=1 in the same cycle, dmem_req stays 0, stall=0. funct3=011 load → fault=1.
- Back-to-back SB then LHU, ready high → the second dmem_req is asserted the cycle after the first DONE.
- rst pulsed while in REQ with ready low → dmem_req=0 immediately and state=IDLE. The next op is accepted normally.
